// File: rtl/mem_responder_if.sv
// Avalon-MM style memory bus between a CPU-side master and the memory responder.
// Latency: none (wires only).
// Backpressure: the slave holds waitrequest_o high until it has taken the access.
//
// Ports: address_i/read_i/write_i/byteenable_i/writedata_i run master -> slave;
//        waitrequest_o/readdata_o/error_o run slave -> master.
interface mem_responder_if;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [3:0]  byteenable_i;
    logic [31:0] writedata_i;
    logic        waitrequest_o;
    logic [31:0] readdata_o;
    logic        error_o;

    modport master (
        output address_i, read_i, write_i, byteenable_i, writedata_i,
        input  waitrequest_o, readdata_o, error_o
    );

    modport slave (
        input  address_i, read_i, write_i, byteenable_i, writedata_i,
        output waitrequest_o, readdata_o, error_o
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word RAM responder with byte lanes and a waitrequest handshake.
// Latency: waitrequest high for LATENCY+1 cycles, then low for one ACK cycle.
// Backpressure: master must hold its request while waitrequest_o is high.
//
// Ports: clk, reset (synchronous, active high), bus (mem_responder_if.slave).
//   bus.address_i is a byte address (bits [1:0] ignored), aliased modulo DEPTH_WORDS.
//   bus.readdata_o is valid in the ACK cycle of a read; bus.error_o is sticky.
module mem_responder #(
    parameter logic [31:0] MEM_BASE    = 32'hBFC0_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t         state, state_n;
    logic [3:0]     cnt;
    logic [AW-1:0]  lat_idx;
    logic [3:0]     lat_be;
    logic [31:0]    lat_wdata;
    logic           lat_write;
    logic [31:0]    readdata_q;
    logic           error_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           accept;
    logic           err_set;
    logic           enter_ack;
    logic           rd_op;
    logic [AW-1:0]  cur_idx;
    logic [AW-1:0]  rd_idx;
    logic [3:0]     rd_be;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Truncation to AW bits after the shift gives the modulo aliasing.
    assign cur_idx = AW'((bus.address_i - MEM_BASE) >> 2);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (bus.read_i ^ bus.write_i) begin
                    accept  = 1'b1;
                    state_n = (LATENCY == 0) ? ACK : WAIT;
                end else if (bus.read_i && bus.write_i) begin
                    err_set = 1'b1;
                end
            end
            WAIT: begin
                // Master withdrawing the request takes priority over completion.
                if (!bus.read_i && !bus.write_i) begin
                    state_n = IDLE;
                end else if (cnt == 4'd1) begin
                    state_n = ACK;
                end
            end
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        enter_ack = (state_n == ACK) && (state != ACK);
        // With zero latency ACK is entered straight from IDLE, before the
        // latches hold the request, so the live bus is used in that case.
        rd_op  = (state == IDLE) ? bus.read_i       : !lat_write;
        rd_idx = (state == IDLE) ? cur_idx          : lat_idx;
        rd_be  = (state == IDLE) ? bus.byteenable_i : lat_be;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_idx    <= '0;
            lat_be     <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
            readdata_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                lat_idx   <= cur_idx;
                lat_be    <= bus.byteenable_i;
                lat_wdata <= bus.writedata_i;
                lat_write <= bus.write_i;
                cnt       <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (err_set) begin
                error_q <= 1'b1;
            end
            if (enter_ack && rd_op) begin
                readdata_q <= mem[rd_idx] & lane_mask(rd_be);
            end
        end
    end

    // RAM is not cleared by reset; a reset in the ACK cycle drops the write.
    always_ff @(posedge clk) begin
        if (!reset && state == ACK && lat_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.waitrequest_o = reset | ((bus.read_i | bus.write_i) & (state != ACK));
    assign bus.readdata_o    = readdata_q;
    assign bus.error_o       = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: LATENCY=2 responder (b2) driven from a vector table plus
// hand sequences; a LATENCY=0 responder (b0) for the zero-wait path.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_responder_if b2();
    mem_responder_if b0();

    mem_responder #(.MEM_BASE(32'hBFC0_0000), .DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );
    mem_responder #(.MEM_BASE(32'hBFC0_0000), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_waits;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (sel) begin
            b0.read_i = rd; b0.write_i = wr; b0.address_i = a;
            b0.byteenable_i = be; b0.writedata_i = wd;
        end else begin
            b2.read_i = rd; b2.write_i = wr; b2.address_i = a;
            b2.byteenable_i = be; b2.writedata_i = wd;
        end
    endtask

    function automatic logic get_wait(input bit sel);
        return sel ? b0.waitrequest_o : b2.waitrequest_o;
    endfunction

    function automatic logic [31:0] get_rd(input bit sel);
        return sel ? b0.readdata_o : b2.readdata_o;
    endfunction

    // One complete access; waits counts cycles with waitrequest high (bounded).
    task automatic do_access(input bit sel, input bit wr, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd,
                             output int waits, output logic [31:0] rd);
        @(posedge clk); #1;
        drive(sel, !wr, wr, a, be, wd);
        waits = 0;
        @(negedge clk);
        while (get_wait(sel) && waits <= 40) begin
            waits++;
            @(negedge clk);
        end
        rd = get_rd(sel);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 32'hBFC0_0000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 3};
        vecs[1]  = '{1'b0, 32'hBFC0_0000, 4'b1111, 32'h0,         32'hDEAD_BEEF, 3};
        vecs[2]  = '{1'b1, 32'hBFC0_0000, 4'b1000, 32'h1200_0000, 32'hDEAD_BEEF, 3};
        vecs[3]  = '{1'b0, 32'hBFC0_0000, 4'b1111, 32'h0,         32'h12AD_BEEF, 3};
        vecs[4]  = '{1'b0, 32'hBFC0_0000, 4'b1100, 32'h0,         32'h12AD_0000, 3};
        vecs[5]  = '{1'b0, 32'hBFC0_0000, 4'b0000, 32'h0,         32'h0000_0000, 3};
        vecs[6]  = '{1'b1, 32'hBFC0_0000, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0000, 3};
        vecs[7]  = '{1'b0, 32'hBFC0_0000, 4'b1111, 32'h0,         32'h12AD_BEEF, 3};
        vecs[8]  = '{1'b1, 32'hBFC0_0004, 4'b0101, 32'h00AA_00BB, 32'h12AD_BEEF, 3};
        vecs[9]  = '{1'b0, 32'hBFC0_0004, 4'b0101, 32'h0,         32'h00AA_00BB, 3};
        vecs[10] = '{1'b0, 32'hBFC0_1000, 4'b1111, 32'h0,         32'h12AD_BEEF, 3};
        vecs[11] = '{1'b0, 32'hBFC0_0002, 4'b1111, 32'h0,         32'h12AD_BEEF, 3};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_wait", {31'b0, b2.waitrequest_o}, 32'd1);
        chk("reset_rdata", b2.readdata_o, 32'h0);
        chk("reset_error", {31'b0, b2.error_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_wait", {31'b0, b2.waitrequest_o}, 32'd0);

        // Vector table on the LATENCY=2 responder.
        for (int i = 0; i < 12; i++) begin
            do_access(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, w, rd);
            chk($sformatf("vec%0d_waits", i), w, vecs[i].exp_waits);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // Aborted read of word 1: must not update readdata.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'hBFC0_0004, 4'b1111, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort_rd_hold%0d", k), b2.readdata_o, 32'h12AD_BEEF);
        end

        // Aborted write to word 0: memory must keep its value.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 4'b1111, 32'h0000_0000);
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        do_access(1'b0, 1'b0, 32'hBFC0_0000, 4'b1111, 32'h0, w, rd);
        chk("abort_wr_mem", rd, 32'h12AD_BEEF);

        // Normal write after an abort.
        do_access(1'b0, 1'b1, 32'hBFC0_0008, 4'b1111, 32'h1122_3344, w, rd);
        chk("post_abort_wr_waits", w, 3);
        do_access(1'b0, 1'b0, 32'hBFC0_0008, 4'b1111, 32'h0, w, rd);
        chk("post_abort_rd", rd, 32'h1122_3344);

        // Zero-latency responder, including back-to-back held read.
        do_access(1'b1, 1'b1, 32'hBFC0_0000, 4'b1111, 32'h5566_7788, w, rd);
        chk("lat0_wr_waits", w, 1);
        chk("lat0_wr_rdata", rd, 32'h0);
        do_access(1'b1, 1'b0, 32'hBFC0_0000, 4'b1111, 32'h0, w, rd);
        chk("lat0_rd_waits", w, 1);
        chk("lat0_rd_rdata", rd, 32'h5566_7788);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'hBFC0_0000, 4'b0011, 32'h0);
        @(negedge clk);
        chk("b2b_c0_wait", {31'b0, b0.waitrequest_o}, 32'd1);
        @(negedge clk);
        chk("b2b_c1_wait", {31'b0, b0.waitrequest_o}, 32'd0);
        chk("b2b_c1_rdata", b0.readdata_o, 32'h0000_7788);
        @(negedge clk);
        chk("b2b_c2_wait", {31'b0, b0.waitrequest_o}, 32'd1);
        @(negedge clk);
        chk("b2b_c3_wait", {31'b0, b0.waitrequest_o}, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Simultaneous read and write: sticky error, no memory effect.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'hBFC0_0000, 4'b1111, 32'h0);
        @(negedge clk);
        chk("err_wait", {31'b0, b2.waitrequest_o}, 32'd1);
        @(negedge clk);
        chk("err_set", {31'b0, b2.error_o}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("err_sticky", {31'b0, b2.error_o}, 32'd1);
        do_access(1'b0, 1'b0, 32'hBFC0_0000, 4'b1111, 32'h0, w, rd);
        chk("err_mem", rd, 32'h12AD_BEEF);
        chk("err_sticky2", {31'b0, b2.error_o}, 32'd1);
        pulse_reset();
        @(negedge clk);
        chk("err_cleared", {31'b0, b2.error_o}, 32'd0);

        // Reset during WAIT of a write: write discarded, readdata cleared.
        do_access(1'b0, 1'b0, 32'hBFC0_0000, 4'b1111, 32'h0, w, rd);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 4'b1111, 32'hCAFE_F00D);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_rdata", b2.readdata_o, 32'h0);
        do_access(1'b0, 1'b0, 32'hBFC0_0000, 4'b1111, 32'h0, w, rd);
        chk("rst_mid_mem", rd, 32'h12AD_BEEF);
        do_access(1'b0, 1'b0, 32'hBFC0_1000, 4'b1111, 32'h0, w, rd);
        chk("alias_mem", rd, 32'h12AD_BEEF);
        chk("alias_waits", w, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
